// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data access (DM), one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; otherwise DM has priority with an IF starvation override.
`timescale 1ns/1ps
module unified_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t        r_state;
    state_t        w_state_nxt;
    owner_t        r_owner;
    logic [2:0]    r_lat_cnt;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    logic w_arb_slot;
    logic w_contested;
    logic w_if_wins;
    logic w_dm_wins;
    logic w_capture;

`ifdef ARB_RR_EN
    logic r_if_pri;
`else
    logic [3:0] r_starve_cnt;
`endif

    // RESP doubles as an arbitration slot so back-to-back accesses need no IDLE bubble
    assign w_arb_slot  = (r_state == IDLE) || (r_state == RESP);
    assign w_contested = if_req & dm_req;
    assign w_capture   = (r_state == WAIT) && (r_lat_cnt == 3'd0);

    always_comb begin
        w_if_wins = 1'b0;
        w_dm_wins = 1'b0;
        if (w_arb_slot) begin
            if (w_contested) begin
`ifdef ARB_RR_EN
                w_if_wins = r_if_pri;
`else
                w_if_wins = (r_starve_cnt == 4'(STARVE_MAX));
`endif
                w_dm_wins = ~w_if_wins;
            end else begin
                w_if_wins = if_req;
                w_dm_wins = dm_req;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_valid    = 1'b0;
        dm_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_wins || w_dm_wins) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en      = 1'b1;
                if_gnt      = (r_owner == OWN_IF);
                dm_gnt      = (r_owner == OWN_DM);
                w_state_nxt = WAIT;
            end
            // WAIT spans MEM_LAT cycles; the last one is where mem_rdata is valid
            WAIT: begin
                if (r_lat_cnt == 3'd0) w_state_nxt = RESP;
            end
            RESP: begin
                if_valid    = (r_owner == OWN_IF);
                dm_valid    = (r_owner == OWN_DM);
                w_state_nxt = (w_if_wins || w_dm_wins) ? ISSUE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_we    = r_mem_we & mem_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            r_lat_cnt <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_if_wins)             r_owner <= OWN_IF;
            else if (w_dm_wins)        r_owner <= OWN_DM;
            else if (r_state == RESP)  r_owner <= OWN_NONE;
            if (r_state == ISSUE)
                r_lat_cnt <= 3'(MEM_LAT - 1);
            else if (r_state == WAIT && r_lat_cnt != 3'd0)
                r_lat_cnt <= r_lat_cnt - 3'd1;
        end
    end

`ifdef ARB_RR_EN
    // The loser of a contested arbitration takes priority next time
    always_ff @(posedge clk) begin
        if (rst)              r_if_pri <= 1'b0;
        else if (w_contested && (w_if_wins || w_dm_wins))
                              r_if_pri <= w_dm_wins;
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            r_starve_cnt <= 4'd0;
        else if (w_if_wins)
            r_starve_cnt <= 4'd0;
        else if (w_dm_wins && w_contested && r_starve_cnt != 4'(STARVE_MAX))
            r_starve_cnt <= r_starve_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_if_wins) begin
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= '0;
            end else if (w_dm_wins) begin
                r_mem_addr  <= dm_addr;
                r_mem_we    <= dm_we;
                r_mem_wdata <= dm_wdata;
            end
            if (w_capture) begin
                if (r_owner == OWN_IF)
                    r_if_rdata <= mem_rdata;
                else if (r_owner == OWN_DM)
                    r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: memory model, event monitor and per-scenario scoreboard tasks.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int SMAX = 3;

    typedef struct packed {
        logic          is_dm;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (a == 16'h0004) ? 16'h1234 : (a ^ 16'hC3A5);
    endfunction

    // Memory model: read data appears LAT cycles after the mem_en cycle
    logic [DW-1:0] wr_m [256];
    bit            wr_v [256];
    logic [DW-1:0] rd_pipe [LAT];
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_m[mem_addr[7:0]] <= mem_wdata;
            wr_v[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_en && !mem_we)
            rd_pipe[0] <= wr_v[mem_addr[7:0]] ? wr_m[mem_addr[7:0]] : pat(mem_addr);
        else
            rd_pipe[0] <= 16'hDEAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Event monitor: logs grants and responses for the scenario tasks
    int            cyc = 0;
    bit            g_log [256];
    int            g_t   [256];
    int            g_n = 0;
    bit            r_dm  [256];
    logic [DW-1:0] r_data [256];
    int            r_n = 0;
    int            bad_we = 0;
    int            both_gnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (if_gnt || dm_gnt) begin
            g_log[g_n & 255] <= dm_gnt;
            g_t[g_n & 255]   <= cyc;
            g_n              <= g_n + 1;
        end
        if (if_valid || dm_valid) begin
            r_dm[r_n & 255]   <= dm_valid;
            r_data[r_n & 255] <= dm_valid ? dm_rdata : if_rdata;
            r_n               <= r_n + 1;
        end
        if (mem_we && !mem_en) bad_we <= bad_we + 1;
        if (if_gnt && dm_gnt) both_gnt <= both_gnt + 1;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t exp_q[$];
    int   rd_i = 0;

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_and_wait(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (if_valid) if_req = 1'b0;
            if (dm_valid) dm_req = 1'b0;
            if (!if_req && !dm_req) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we} !== 6'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b expected 000000", {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we});
        end
        n_checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            n_errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (if_rdata !== 16'h0 || dm_rdata !== 16'h0) begin
            n_errors++; $display("FAIL reset_rdata: got if %h dm %h expected 0", if_rdata, dm_rdata);
        end
        n_checks++;
        if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall_idle: got %b%b expected 00", stall_if, stall_mem);
        end
        if_req = 1'b1; dm_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_if !== 1'b1 || stall_mem !== 1'b1 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall_req: got stall %b%b gnt %b%b expected 11 00", stall_if, stall_mem, if_gnt, dm_gnt);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_if_read();
        rsp_t e;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0004;
        exp_q.push_back('{1'b0, 16'h1234});
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (if_gnt !== 1'(c == 1) || mem_en !== 1'(c == 1)) begin
                n_errors++; $display("FAIL if_gnt_en c%0d: got gnt %b en %b expected %b", c, if_gnt, mem_en, (c == 1));
            end
            n_checks++;
            if (if_valid !== 1'(c == LAT + 2)) begin
                n_errors++; $display("FAIL if_valid c%0d: got %b expected %b", c, if_valid, (c == LAT + 2));
            end
            n_checks++;
            if (stall_if !== 1'(c <= LAT + 1)) begin
                n_errors++; $display("FAIL if_stall c%0d: got %b expected %b", c, stall_if, (c <= LAT + 1));
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr !== 16'h0004 || mem_we !== 1'b0) begin
                    n_errors++; $display("FAIL if_issue_bus: got addr %h we %b expected 0004 0", mem_addr, mem_we);
                end
            end
            if (c == LAT + 2) begin
                n_checks++;
                if (if_rdata !== 16'h1234) begin
                    n_errors++; $display("FAIL if_rdata: got %h expected 1234", if_rdata);
                end
            end
            #1;
            if (if_valid) if_req = 1'b0;
        end
        n_checks++;
        if (r_n - rd_i != exp_q.size()) begin
            n_errors++; $display("FAIL if_rsp_count: got %0d expected %0d", r_n - rd_i, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_i < r_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_dm[rd_i & 255] !== e.is_dm || r_data[rd_i & 255] !== e.data) begin
                n_errors++; $display("FAIL if_sb: got dm=%b %h expected dm=%b %h", r_dm[rd_i & 255], r_data[rd_i & 255], e.is_dm, e.data);
            end
            rd_i++;
        end
        exp_q.delete(); rd_i = r_n;
    endtask

    task automatic test_dm_write();
        rsp_t e;
        int   we_cycles = 0;
        bit   ok;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
        exp_q.push_back('{1'b1, 16'h0000});
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cycles++;
            n_checks++;
            if ((mem_en & mem_we) !== 1'(c == 1) || dm_gnt !== 1'(c == 1)) begin
                n_errors++; $display("FAIL dm_wr_strobe c%0d: got en&we %b gnt %b expected %b", c, mem_en & mem_we, dm_gnt, (c == 1));
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
                    n_errors++; $display("FAIL dm_wr_bus: got %h %h expected 0010 beef", mem_addr, mem_wdata);
                end
            end
            n_checks++;
            if (dm_valid !== 1'(c == LAT + 2) || stall_mem !== 1'(c <= LAT + 1)) begin
                n_errors++; $display("FAIL dm_wr_valid c%0d: got valid %b stall %b", c, dm_valid, stall_mem);
            end
            if (c == LAT + 2) begin
                n_checks++;
                if (dm_rdata !== 16'h0000) begin
                    n_errors++; $display("FAIL dm_wr_rdata: got %h expected 0000", dm_rdata);
                end
            end
            #1;
            if (dm_valid) dm_req = 1'b0;
        end
        n_checks++;
        if (we_cycles != 1) begin
            n_errors++; $display("FAIL dm_wr_we_cycles: got %0d expected 1", we_cycles);
        end
        // read back the written word
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010; dm_wdata = 16'h0000;
        exp_q.push_back('{1'b1, 16'hBEEF});
        drive_and_wait(40, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL dm_rd_timeout: got no dm_valid expected one");
        end
        n_checks++;
        if (dm_rdata !== 16'hBEEF) begin
            n_errors++; $display("FAIL dm_rd_hold: got %h expected beef", dm_rdata);
        end
        n_checks++;
        if (r_n - rd_i != exp_q.size()) begin
            n_errors++; $display("FAIL dm_rsp_count: got %0d expected %0d", r_n - rd_i, exp_q.size());
        end
        while (exp_q.size() > 0 && rd_i < r_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_dm[rd_i & 255] !== e.is_dm || r_data[rd_i & 255] !== e.data) begin
                n_errors++; $display("FAIL dm_sb: got dm=%b %h expected dm=%b %h", r_dm[rd_i & 255], r_data[rd_i & 255], e.is_dm, e.data);
            end
            rd_i++;
        end
        exp_q.delete(); rd_i = r_n;
    endtask

    task automatic test_arbitration();
        rsp_t e;
        bit   exp_g[$];
        bit   done = 1'b0;
        int   gbase;
        do_reset();
`ifdef ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        foreach (exp_g[i])
            exp_q.push_back(exp_g[i] ? '{1'b1, pat(16'h0041)} : '{1'b0, pat(16'h0040)});
        gbase = g_n; rd_i = r_n;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0041;
        for (int k = 0; k < 8 * (LAT + 2) + 20; k++) begin
            @(negedge clk); #1;
            if (r_n - rd_i >= 8) begin
                if_req = 1'b0; dm_req = 1'b0; done = 1'b1;
                break;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++; $display("FAIL arb_timeout: got %0d responses expected 8", r_n - rd_i);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (g_n - gbase <= i || g_log[(gbase + i) & 255] !== exp_g[i]) begin
                n_errors++; $display("FAIL arb_order #%0d: got dm=%b expected dm=%b", i, g_log[(gbase + i) & 255], exp_g[i]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (g_t[(gbase + i + 1) & 255] - g_t[(gbase + i) & 255] != LAT + 2) begin
                n_errors++; $display("FAIL arb_spacing #%0d: got %0d expected %0d", i,
                                     g_t[(gbase + i + 1) & 255] - g_t[(gbase + i) & 255], LAT + 2);
            end
        end
        while (exp_q.size() > 0 && rd_i < r_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_dm[rd_i & 255] !== e.is_dm || r_data[rd_i & 255] !== e.data) begin
                n_errors++; $display("FAIL arb_sb: got dm=%b %h expected dm=%b %h", r_dm[rd_i & 255], r_data[rd_i & 255], e.is_dm, e.data);
            end
            rd_i++;
        end
        exp_q.delete(); rd_i = r_n;
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        bit   ok;
        int   rbase;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0020;
        rbase = r_n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem} !== 8'b0) begin
            n_errors++; $display("FAIL rstmid_ctrl: got %b expected 00000000",
                                 {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem});
        end
        n_checks++;
        if (mem_addr !== 16'h0 || if_rdata !== 16'h0 || dm_rdata !== 16'h0) begin
            n_errors++; $display("FAIL rstmid_data: got addr %h if %h dm %h expected 0", mem_addr, if_rdata, dm_rdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        n_checks++;
        if (r_n != rbase) begin
            n_errors++; $display("FAIL rstmid_no_valid: got %0d responses expected 0", r_n - rbase);
        end
        rd_i = r_n;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0030;
        exp_q.push_back('{1'b0, pat(16'h0030)});
        drive_and_wait(40, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL rstmid_timeout: got no if_valid expected one");
        end
        while (exp_q.size() > 0 && rd_i < r_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_dm[rd_i & 255] !== e.is_dm || r_data[rd_i & 255] !== e.data) begin
                n_errors++; $display("FAIL rstmid_sb: got dm=%b %h expected dm=%b %h", r_dm[rd_i & 255], r_data[rd_i & 255], e.is_dm, e.data);
            end
            rd_i++;
        end
        exp_q.delete(); rd_i = r_n;
    endtask

    task automatic test_dm_drop();
        rsp_t e;
        bit   ok;
        int   gbase;
        gbase = g_n; rd_i = r_n;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0050;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0051;
        exp_q.push_back('{1'b0, pat(16'h0050)});
        @(negedge clk); #1 dm_req = 1'b0;
        drive_and_wait(40, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL drop_timeout: got no if_valid expected one");
        end
        n_checks++;
        if (g_n - gbase != 1 || g_log[gbase & 255] !== 1'b0) begin
            n_errors++; $display("FAIL drop_gnt: got %0d grants first dm=%b expected 1 IF grant", g_n - gbase, g_log[gbase & 255]);
        end
        while (exp_q.size() > 0 && rd_i < r_n) begin
            e = exp_q.pop_front();
            n_checks++;
            if (r_dm[rd_i & 255] !== e.is_dm || r_data[rd_i & 255] !== e.data) begin
                n_errors++; $display("FAIL drop_sb: got dm=%b %h expected dm=%b %h", r_dm[rd_i & 255], r_data[rd_i & 255], e.is_dm, e.data);
            end
            rd_i++;
        end
        exp_q.delete(); rd_i = r_n;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_arbitration();
        test_reset_mid();
        test_dm_drop();
        n_checks++;
        if (bad_we != 0 || both_gnt != 0) begin
            n_errors++; $display("FAIL protocol: got we-outside-en %0d double-gnt %0d expected 0 0", bad_we, both_gnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
